// File: rtl/random_matrix_filler_if.sv
// rtl/random_matrix_filler_if.sv - request, generator and matrix-write signals of random_matrix_filler
// slave = the filler itself, master = menu control / generator / matrix RAM side.
interface random_matrix_filler_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 5
);
  logic              start;
  logic [2:0]        rows;
  logic [2:0]        cols;
  logic [WIDTH-1:0]  min_val;
  logic [WIDTH-1:0]  max_val;
  logic              rng_en;
  logic [WIDTH-1:0]  rng_min;
  logic [WIDTH-1:0]  rng_max;
  logic [WIDTH-1:0]  rng_num;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  start, rows, cols, min_val, max_val, rng_num,
    output rng_en, rng_min, rng_max, wr_en, wr_addr, wr_data, busy, done, err
  );

  modport master (
    output start, rows, cols, min_val, max_val, rng_num,
    input  rng_en, rng_min, rng_max, wr_en, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/random_matrix_filler.sv
// rtl/random_matrix_filler.sv - fills a rows x cols matrix row-major from a random number generator
// Optional macro FILL_CLAMP_EN: clamp each sample into [rng_min, rng_max] before it is written.
module random_matrix_filler #(
  parameter int WIDTH    = 8,
  parameter int MAX_ROWS = 5,
  parameter int MAX_COLS = 5,
  parameter int ADDR_W   = 5,
  parameter int RNG_LAT  = 1
) (
  input logic                   i_clk,
  input logic                   i_rst,
  random_matrix_filler_if.slave bus
);
  localparam int CNT_W = (RNG_LAT > 1) ? $clog2(RNG_LAT) : 1;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RNG_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_REQ, S_WAIT, S_WRITE, S_DONE} state_t;

  state_t            r_state;
  logic [2:0]        r_rows;
  logic [2:0]        r_cols;
  logic [2:0]        r_row;
  logic [2:0]        r_col;
  logic [WIDTH-1:0]  r_min;
  logic [WIDTH-1:0]  r_max;
  logic [WIDTH-1:0]  r_wr_data;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [CNT_W-1:0]  r_lat_cnt;
  logic              r_rng_en;
  logic              r_wr_en;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_bad;
  logic              w_last_col;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr;
  logic [WIDTH-1:0]  w_fill_data;

  assign w_bad = (r_rows == 3'd0) || (r_cols == 3'd0)
              || ({1'b0, r_rows} > 4'(MAX_ROWS)) || ({1'b0, r_cols} > 4'(MAX_COLS))
              || (r_min > r_max);

  assign w_last_col = (r_col == r_cols - 3'd1);
  assign w_last     = w_last_col && (r_row == r_rows - 3'd1);
  assign w_addr     = ADDR_W'(r_row) * ADDR_W'(MAX_COLS) + ADDR_W'(r_col);

`ifdef FILL_CLAMP_EN
  logic [WIDTH-1:0] w_lo_clamped;
  assign w_lo_clamped = (bus.rng_num < r_min) ? r_min : bus.rng_num;
  assign w_fill_data  = (w_lo_clamped > r_max) ? r_max : w_lo_clamped;
`else
  assign w_fill_data = bus.rng_num;
`endif

  // Outputs are registered alongside the state they belong to, so each pulse lines up with its state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_rows    <= '0;
      r_cols    <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_min     <= '0;
      r_max     <= '0;
      r_wr_data <= '0;
      r_wr_addr <= '0;
      r_lat_cnt <= '0;
      r_rng_en  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_rng_en <= 1'b0;
      r_wr_en  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_rows  <= bus.rows;
            r_cols  <= bus.cols;
            r_min   <= bus.min_val;
            r_max   <= bus.max_val;
            r_busy  <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_bad) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_row    <= '0;
            r_col    <= '0;
            r_rng_en <= 1'b1;
            r_state  <= S_REQ;
          end
        end
        S_REQ: begin
          r_lat_cnt <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (r_lat_cnt == LAT_LAST) begin
            r_wr_en   <= 1'b1;
            r_wr_data <= w_fill_data;
            r_wr_addr <= w_addr;
            r_state   <= S_WRITE;
          end else begin
            r_lat_cnt <= r_lat_cnt + 1'b1;
          end
        end
        S_WRITE: begin
          if (w_last) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            if (w_last_col) begin
              r_col <= '0;
              r_row <= r_row + 3'd1;
            end else begin
              r_col <= r_col + 3'd1;
            end
            r_rng_en <= 1'b1;
            r_state  <= S_REQ;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rng_en  = r_rng_en;
  assign bus.rng_min = r_min;
  assign bus.rng_max = r_max;
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
endmodule

// File: tb/tb_random_matrix_filler.sv
// tb/tb_random_matrix_filler.sv - directed bench for random_matrix_filler with a 1-cycle generator model
// Expected clamp results follow FILL_CLAMP_EN the same way the design does.
module tb_random_matrix_filler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  random_matrix_filler_if #(.WIDTH(8), .ADDR_W(5)) bus ();

  random_matrix_filler #(
    .WIDTH(8), .MAX_ROWS(5), .MAX_COLS(5), .ADDR_W(5), .RNG_LAT(1)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Generator model: value = 8'h40 + request count, or two override values when ovr_en is set.
  int       gen_cnt = 0;
  logic     ovr_en  = 1'b0;
  int       ovr_base = 0;
  logic [7:0] ovr_v0 = 8'h00;
  logic [7:0] ovr_v1 = 8'h00;
  always @(posedge clk) begin
    if (bus.rng_en) begin
      if (ovr_en) bus.rng_num <= (gen_cnt == ovr_base) ? ovr_v0 : ovr_v1;
      else        bus.rng_num <= 8'(8'h40 + gen_cnt);
      gen_cnt <= gen_cnt + 1;
    end
  end

  int cyc = 0;
  int n_rng, n_wr, n_done, n_err, n_busy, n_overlap;
  int last_busy_cyc, done_cyc, err_cyc;
  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_cyc_q[$];
  int rng_cyc_q[$];
  logic log_clear = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (log_clear) begin
      n_rng = 0; n_wr = 0; n_done = 0; n_err = 0; n_busy = 0; n_overlap = 0;
      last_busy_cyc = -1; done_cyc = -1; err_cyc = -1;
      wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); rng_cyc_q.delete();
    end else begin
      if (bus.rng_en) begin n_rng++; rng_cyc_q.push_back(cyc); end
      if (bus.wr_en) begin
        n_wr++;
        wr_addr_q.push_back(int'(bus.wr_addr));
        wr_data_q.push_back(int'(bus.wr_data));
        wr_cyc_q.push_back(cyc);
      end
      if (bus.done) begin n_done++; done_cyc = cyc; end
      if (bus.err)  begin n_err++;  err_cyc  = cyc; end
      if (bus.busy) begin n_busy++; last_busy_cyc = cyc; end
      if ((int'(bus.rng_en) + int'(bus.wr_en) + int'(bus.done)) > 1) n_overlap++;
    end
  end

  task automatic clear_log();
    @(posedge clk); #1 log_clear = 1'b1;
    @(posedge clk); #1 log_clear = 1'b0;
  endtask

  task automatic do_start(input int r, input int c, input int mn, input int mx);
    @(posedge clk); #1;
    bus.rows = 3'(r); bus.cols = 3'(c); bus.min_val = 8'(mn); bus.max_val = 8'(mx);
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int k = 0;
    while (n_done == 0 && n_err == 0 && k < budget) begin
      @(negedge clk); k++;
    end
    check({tag, "_finished_in_time"}, int'(k < budget), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rng_en"},  int'(bus.rng_en),  0);
    check({tag, "_wr_en"},   int'(bus.wr_en),   0);
    check({tag, "_busy"},    int'(bus.busy),    0);
    check({tag, "_done"},    int'(bus.done),    0);
    check({tag, "_err"},     int'(bus.err),     0);
    check({tag, "_wr_addr"}, int'(bus.wr_addr), 0);
    check({tag, "_wr_data"}, int'(bus.wr_data), 0);
    check({tag, "_rng_min"}, int'(bus.rng_min), 0);
    check({tag, "_rng_max"}, int'(bus.rng_max), 0);
  endtask

  int base;
  int exp_addr1[6] = '{0, 1, 2, 5, 6, 7};
  int exp_addr4[4] = '{0, 1, 5, 6};
  int bad_r[4]  = '{0, 6, 2, 3};
  int bad_c[4]  = '{3, 3, 2, 6};
  int bad_mn[4] = '{0, 0, 9, 0};
  int bad_mx[4] = '{15, 15, 3, 15};

  initial begin
    bus.start = 1'b0; bus.rows = '0; bus.cols = '0; bus.min_val = '0; bus.max_val = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Test 1: 2x3 fill
    clear_log();
    base = gen_cnt;
    do_start(2, 3, 0, 15);
    wait_end("t1", 100);
    check("t1_writes", n_wr, 6);
    check("t1_rng_en", n_rng, 6);
    check("t1_done", n_done, 1);
    check("t1_err", n_err, 0);
    check("t1_overlap", n_overlap, 0);
    check("t1_busy_drops_with_done", last_busy_cyc, done_cyc);
    for (int i = 0; i < 6 && i < n_wr; i++) begin
      check($sformatf("t1_addr%0d", i), wr_addr_q[i], exp_addr1[i]);
      check($sformatf("t1_data%0d", i), wr_data_q[i], (8'h40 + base + i) & 8'hFF);
      check($sformatf("t1_rng_lead%0d", i), wr_cyc_q[i] - rng_cyc_q[i], 2);
    end

    // Test 2: rejected requests
    for (int t = 0; t < 4; t++) begin
      clear_log();
      do_start(bad_r[t], bad_c[t], bad_mn[t], bad_mx[t]);
      wait_end($sformatf("t2_%0d", t), 20);
      check($sformatf("t2_%0d_err", t), n_err, 1);
      check($sformatf("t2_%0d_rng_en", t), n_rng, 0);
      check($sformatf("t2_%0d_wr_en", t), n_wr, 0);
      check($sformatf("t2_%0d_busy_cycles", t), n_busy, 1);
      check($sformatf("t2_%0d_err_after_check", t), err_cyc, last_busy_cyc + 1);
    end

    // Test 3: 1x1
    clear_log();
    do_start(1, 1, 0, 255);
    wait_end("t3", 30);
    check("t3_rng_en", n_rng, 1);
    check("t3_writes", n_wr, 1);
    if (n_wr > 0) check("t3_addr", wr_addr_q[0], 0);
    check("t3_done", n_done, 1);
    check("t3_busy_cycles", n_busy, 5);

    // Test 4: start and rows change mid-fill are ignored
    clear_log();
    do_start(2, 2, 0, 255);
    repeat (3) @(posedge clk);
    #1 bus.rows = 3'd5; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_end("t4", 60);
    repeat (20) @(negedge clk);
    check("t4_writes", n_wr, 4);
    check("t4_done", n_done, 1);
    for (int i = 0; i < 4 && i < n_wr; i++)
      check($sformatf("t4_addr%0d", i), wr_addr_q[i], exp_addr4[i]);

    // Test 5: reset during the third element of a 5x5 fill
    clear_log();
    do_start(5, 5, 1, 200);
    for (int k = 0; k < 50 && n_rng < 3; k++) @(negedge clk);
    check("t5_third_request_seen", n_rng, 3);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("t5_after_rst");
    check("t5_partial_writes", n_wr, 2);
    rst = 1'b0;
    clear_log();
    do_start(5, 5, 0, 255);
    wait_end("t5_refill", 200);
    check("t5_writes", n_wr, 25);
    check("t5_done", n_done, 1);
    for (int i = 0; i < 25 && i < n_wr; i++)
      check($sformatf("t5_addr%0d", i), wr_addr_q[i], (i / 5) * 5 + (i % 5));

    // Test 6: out-of-range generator values
    clear_log();
    ovr_base = gen_cnt; ovr_v0 = 8'h05; ovr_v1 = 8'h30; ovr_en = 1'b1;
    do_start(1, 2, 8'h10, 8'h1F);
    wait_end("t6", 40);
    ovr_en = 1'b0;
    check("t6_writes", n_wr, 2);
    if (n_wr == 2) begin
`ifdef FILL_CLAMP_EN
      check("t6_data0", wr_data_q[0], 8'h10);
      check("t6_data1", wr_data_q[1], 8'h1F);
`else
      check("t6_data0", wr_data_q[0], 8'h05);
      check("t6_data1", wr_data_q[1], 8'h30);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end
endmodule
